bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NO_MASTERS, default 2, number of requesting masters (2..8).
REQ-002 Parameter NO_SLAVES, default 3, number of addressable slaves.
REQ-003 Parameter S_ID_WIDTH, default $clog2(NO_SLAVES+1), slave id width; id 0 = no slave.
REQ-004 Parameter M_ID_WIDTH, default $clog2(NO_MASTERS), master index width.
REQ-005 Parameter TIMEOUT_CYCLES, default 256, BUSY-state hold limit (used only with ARB_TIMEOUT_EN).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rstN  input  1  asynchronous, active-low reset.
REQ-008 req  input  NO_MASTERS  per-master bus request, level.
REQ-009 slave_id  input  NO_MASTERS*S_ID_WIDTH  per-master target slave; master m at bits [m*S_ID_WIDTH +: S_ID_WIDTH].
REQ-010 done  input  NO_MASTERS  per-master transfer-complete, sampled only for the granted master.
REQ-011 grant  output  NO_MASTERS  one-hot grant, registered.
REQ-012 master_sel  output  M_ID_WIDTH  index of owning master, drives the bus muxes, registered.
REQ-013 slave_sel  output  S_ID_WIDTH  selected slave id, 0 when bus not owned, registered.
REQ-014 bus_busy  output  1  high in GRANT, BUSY and RELEASE.
REQ-015 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-016 FSM states IDLE, GRANT, BUSY, RELEASE; all outputs registered from state and latched fields.
REQ-017 Valid request: req[m]=1 and slave_id[m] in 1..NO_SLAVES; others are ignored in every state.
REQ-018 IDLE: grant=0, slave_sel=0, bus_busy=0; on any valid request, select winner by round-robin, latch master_sel and slave_sel, go to GRANT next edge.
REQ-019 Round-robin: search starts at (last_owner+1) mod NO_MASTERS, ascending, wrapping; last_owner resets to NO_MASTERS-1 so master 0 wins the first contention.
REQ-020 GRANT: exactly one cycle; grant[master_sel]=1, slave_sel=latched id, bus_busy=1; next state BUSY unconditionally.
REQ-021 BUSY: grant, master_sel, slave_sel held; go to RELEASE on done[master_sel]=1 or req[master_sel]=0.
REQ-022 RELEASE: exactly one cycle; grant=0, slave_sel=0, master_sel held, bus_busy=1; last_owner<=master_sel; next state IDLE.
REQ-023 Latency: valid request present in IDLE at edge N -> grant high after edge N+1; done at edge K -> grant low after K+1; earliest new grant after edge K+3.
REQ-024 Changes to slave_id, req or done of non-owning masters while bus_busy=1 have no effect.
REQ-025 grant is never multi-hot; grant=0 in IDLE and RELEASE.
REQ-026 done and req-drop of owner in same cycle: single RELEASE, no double transition.

Reset
REQ-027 rstN low asynchronously forces state IDLE, grant=0, master_sel=0, slave_sel=0, bus_busy=0, timeout=0, last_owner=NO_MASTERS-1, timeout counter=0.
REQ-028 Reset asserted mid-transfer drops grant immediately without passing RELEASE; first valid request after rstN rises is arbitrated as from reset.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: BUSY-cycle counter clears on entry to BUSY; if done/req-drop absent when counter reaches TIMEOUT_CYCLES-1, FSM goes to RELEASE and timeout=1 for that RELEASE cycle only.
REQ-030 ARB_TIMEOUT_EN undefined: no counter; timeout tied 0; BUSY held indefinitely until done or req-drop.

Verification
REQ-031 Reset, then req=2'b01, slave_id[0]=2 -> grant=01, master_sel=0, slave_sel=2 one cycle after request; done[0] pulse -> grant=00, slave_sel=0 next cycle, bus_busy low one cycle later.
REQ-032 req=2'b11 held, each owner pulses done after 3 BUSY cycles -> grants alternate 01,10,01,10; never both.
REQ-033 req[1]=1 with slave_id[1]=0 -> grant stays 00, bus_busy=0; change slave_id[1] to 3 -> grant=10, slave_sel=3.
REQ-034 Master 0 owns bus, master 1 changes slave_id 1->3 mid-BUSY -> slave_sel unchanged until RELEASE; master 1 granted with id 3 afterwards.
REQ-035 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, owner never asserts done -> RELEASE after 8 BUSY cycles, timeout one-cycle pulse, other requester granted next; without macro, grant held for 100 cycles, timeout=0.
REQ-036 rstN pulsed low during BUSY -> grant, slave_sel, bus_busy zero within same cycle; after release master 0 wins simultaneous req=2'b11.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Arbiter bus interface: per-master request/target/done in, registered grant/select out.
// The master modport is the requester side; the slave modport is the arbiter side.
interface bus_arbiter_if #(
  parameter int unsigned NO_MASTERS = 2,
  parameter int unsigned NO_SLAVES  = 3,
  parameter int unsigned S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int unsigned M_ID_WIDTH = $clog2(NO_MASTERS)
);
  logic [NO_MASTERS-1:0]            req;
  logic [NO_MASTERS*S_ID_WIDTH-1:0] slave_id;
  logic [NO_MASTERS-1:0]            done;
  logic [NO_MASTERS-1:0]            grant;
  logic [M_ID_WIDTH-1:0]            master_sel;
  logic [S_ID_WIDTH-1:0]            slave_sel;
  logic                             bus_busy;
  logic                             timeout;

  modport master (
    output req, slave_id, done,
    input  grant, master_sel, slave_sel, bus_busy, timeout
  );

  modport slave (
    input  req, slave_id, done,
    output grant, master_sel, slave_sel, bus_busy, timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: IDLE -> GRANT -> BUSY -> RELEASE -> IDLE.
// All outputs are registered; they are computed from the next state so that they
// change on the same edge as the state.
// Optional feature: define ARB_TIMEOUT_EN to force a release after TIMEOUT_CYCLES
// BUSY cycles without done/req-drop (timeout pulses for that RELEASE cycle).
module bus_arbiter #(
  parameter int unsigned NO_MASTERS     = 2,
  parameter int unsigned NO_SLAVES      = 3,
  parameter int unsigned S_ID_WIDTH     = $clog2(NO_SLAVES + 1),
  parameter int unsigned M_ID_WIDTH     = $clog2(NO_MASTERS),
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rstN,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StBusy, StRelease} state_e;

  localparam logic [S_ID_WIDTH-1:0] MaxId = S_ID_WIDTH'(NO_SLAVES);
  localparam logic [M_ID_WIDTH-1:0] LastOwnerRst = M_ID_WIDTH'(NO_MASTERS - 1);

  if (NO_MASTERS < 2 || NO_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_arbiter: illegal parameter value");
  end

  state_e                               state_q, state_d;
  logic [M_ID_WIDTH-1:0]                master_sel_q, master_sel_d;
  logic [M_ID_WIDTH-1:0]                last_owner_q, last_owner_d;
  logic [S_ID_WIDTH-1:0]                slave_sel_q, slave_sel_d;
  logic [NO_MASTERS-1:0]                grant_q, grant_d;
  logic                                 bus_busy_q, bus_busy_d;

  logic [NO_MASTERS-1:0][S_ID_WIDTH-1:0] sid_a;
  logic [NO_MASTERS-1:0]                valid;
  logic                                 win_found;
  logic [M_ID_WIDTH-1:0]                win_idx;
  logic [S_ID_WIDTH-1:0]                win_sid;
  logic                                 owner_end;

  assign sid_a = bus.slave_id;

  // A request only counts when it targets an existing slave (id 0 means none).
  for (genvar g = 0; g < NO_MASTERS; g++) begin : g_valid
    assign valid[g] = bus.req[g] && (sid_a[g] != '0) && (sid_a[g] <= MaxId);
  end

  // Owner finished: done or request withdrawn; other masters' inputs are ignored.
  assign owner_end = bus.done[master_sel_q] || !bus.req[master_sel_q];

  // Round-robin search starting just after the last owner, wrapping.
  always_comb begin
    logic [M_ID_WIDTH-1:0] idx_m;
    win_found = 1'b0;
    win_idx   = '0;
    win_sid   = '0;
    idx_m     = '0;
    for (int unsigned i = 0; i < NO_MASTERS; i++) begin
      idx_m = M_ID_WIDTH'((32'(last_owner_q) + 32'd1 + i) % NO_MASTERS);
      if (!win_found && valid[idx_m]) begin
        win_found = 1'b1;
        win_idx   = idx_m;
        win_sid   = sid_a[idx_m];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Next-state logic and registered-output precomputation.
  always_comb begin
    state_d      = state_q;
    master_sel_d = master_sel_q;
    last_owner_d = last_owner_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d      = StGrant;
          master_sel_d = win_idx;
        end
      end
      StGrant: begin
        state_d = StBusy;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StBusy: begin
        if (owner_end) begin
          state_d = StRelease;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d   = StRelease;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StRelease: begin
        state_d      = StIdle;
        last_owner_d = master_sel_q;
      end
      default: state_d = StIdle;
    endcase

    grant_d     = '0;
    slave_sel_d = '0;
    bus_busy_d  = (state_d != StIdle);
    if (state_d == StGrant || state_d == StBusy) begin
      grant_d     = {{(NO_MASTERS - 1){1'b0}}, 1'b1} << master_sel_d;
      // Target id is captured once at arbitration and held for the tenure.
      slave_sel_d = (state_q == StIdle) ? win_sid : slave_sel_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StIdle;
      master_sel_q <= '0;
      last_owner_q <= LastOwnerRst;
      slave_sel_q  <= '0;
      grant_q      <= '0;
      bus_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      master_sel_q <= master_sel_d;
      last_owner_q <= last_owner_d;
      slave_sel_q  <= slave_sel_d;
      grant_q      <= grant_d;
      bus_busy_q   <= bus_busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // BUSY-cycle counter and timeout pulse register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant      = grant_q;
  assign bus.master_sel = master_sel_q;
  assign bus.slave_sel  = slave_sel_q;
  assign bus.bus_busy   = bus_busy_q;

endmodule
